// File: rtl/rom_strobe_generator.sv
// ROM control strobe generator: timed SETUP/ACTIVE/HOLD pulse trains with sample and done pulses.
// Optional abort input enabled by defining STROBE_ABORT_EN.
module rom_strobe_generator #(
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned ACTIVE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter logic        IDLE_LEVEL    = 1'b1,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] repeat_count,
`ifdef STROBE_ABORT_EN
  input  logic        abort,
`endif
  output logic        ready,
  output logic        strobe,
  output logic        sample,
  output logic        done
);

  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned RW = 16;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ACTIVE_LAST = CW'(ACTIVE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES == 0 || ACTIVE_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_param_err
    $error("rom_strobe_generator: SETUP/ACTIVE/HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_rem, w_rem_nxt;
  logic          r_ready, r_strobe, r_sample, r_done;
  logic          w_ready_nxt, w_strobe_nxt, w_sample_nxt, w_done_nxt;
  logic          w_abort;

`ifdef STROBE_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Next state, counter and remaining-pulse bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_SETUP;
          w_rem_nxt   = (repeat_count == RW'(0)) ? RW'(1) : repeat_count;
        end
      end
      S_SETUP: begin
        if (w_abort) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rem_nxt   = RW'(1);
        end else if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_ACTIVE: begin
        if (w_abort) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_rem_nxt   = RW'(1);
        end else if (r_cnt == ACTIVE_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt = '0;
          if (r_rem > RW'(1)) begin
            w_state_nxt = S_SETUP;
            w_rem_nxt   = r_rem - RW'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Outputs are precomputed from the next state so they register alongside it
    w_ready_nxt  = (w_state_nxt == S_IDLE);
    w_strobe_nxt = (w_state_nxt == S_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
    w_sample_nxt = (w_state_nxt == S_ACTIVE) && (w_cnt_nxt == ACTIVE_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_ready  <= 1'b1;
      r_strobe <= IDLE_LEVEL;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_ready  <= w_ready_nxt;
      r_strobe <= w_strobe_nxt;
      r_sample <= w_sample_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ready  = r_ready;
  assign strobe = r_strobe;
  assign sample = r_sample;
  assign done   = r_done;

endmodule

// File: tb/tb_rom_strobe_generator.sv
// Randomized self-checking bench for rom_strobe_generator against a cycle-index waveform model.
module tb_rom_strobe_generator;

  localparam int   S  = 2;
  localparam int   A  = 3;
  localparam int   H  = 2;
  localparam int   P  = S + A + H;
  localparam logic IL = 1'b1;
  localparam int   NEVER = 32'h7fff_ffff;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] repeat_count;
  logic        abort;
  logic        ready, strobe, sample, done;

  rom_strobe_generator #(
    .SETUP_CYCLES (S),
    .ACTIVE_CYCLES(A),
    .HOLD_CYCLES  (H),
    .IDLE_LEVEL   (IL),
    .COUNTER_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .repeat_count(repeat_count),
`ifdef STROBE_ABORT_EN
    .abort       (abort),
`endif
    .ready       (ready),
    .strobe      (strobe),
    .sample      (sample),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the current train: accepted in cycle t0, done in cycle e, aborted in cycle ab_c
  int cyc   = 0;
  int t0    = 0;
  int e     = 0;
  int ab_c  = NEVER;
  bit valid = 0;

  task automatic chk(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, act, exp);
  endtask

  task automatic model(output logic r, output logic s, output logic sm, output logic d);
    int off;
    r = 1'b1; s = IL; sm = 1'b0; d = 1'b0;
    if (valid) begin
      if (cyc > t0 && cyc < e) begin
        r = 1'b0;
        if (cyc <= ab_c) begin
          off = (cyc - t0 - 1) % P;
          if (off >= S && off < S + A) s = ~IL;
          sm = (off == S + A - 1);
        end
      end else if (cyc == e) begin
        d = 1'b1;
      end
    end
  endtask

  task automatic check_cycle();
    logic r, s, sm, d;
    model(r, s, sm, d);
    chk("ready", ready, r);
    chk("strobe", strobe, s);
    chk("sample", sample, sm);
    chk("done", done, d);
  endtask

  // Drive inputs for the current cycle, update the model, advance one clock and check
  task automatic step(input logic st, input logic [15:0] rc, input logic ab);
    logic r, s, sm, d;
    int   off, n;
    start = st; repeat_count = rc; abort = ab;
    model(r, s, sm, d);
    if (ab && valid && reset && cyc > t0 && cyc < e && cyc <= ab_c) begin
      off = (cyc - t0 - 1) % P;
      if (off < S + A) begin
        ab_c = cyc;
        e    = cyc + H + 1;
      end
    end
    if (st && r && reset) begin
      n     = (rc == 16'd0) ? 1 : int'(rc);
      t0    = cyc;
      e     = cyc + n * P + 1;
      ab_c  = NEVER;
      valid = 1;
    end
    @(posedge clk); #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom_range(0, 5)), 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; repeat_count = 16'd0; abort = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_cycle();
    reset = 1'b1;
    idle(2);

    // Single pulse, then a three-pulse train
    step(1'b1, 16'd1, 1'b0); idle(10);
    step(1'b1, 16'd3, 1'b0); idle(25);

    // repeat_count 0 behaves as 1; a start while busy is ignored
    step(1'b1, 16'd0, 1'b0); idle(3);
    step(1'b1, 16'd2, 1'b0); idle(10);

    // Back-to-back trains: start lands in the done cycle
    step(1'b1, 16'd1, 1'b0); idle(7);
    step(1'b1, 16'd1, 1'b0); idle(10);

    // Asynchronous reset mid-ACTIVE
    step(1'b1, 16'd2, 1'b0); idle(4);
    #2 reset = 1'b0;
    #1;
    valid = 0;
    chk("async_rst_strobe", strobe, IL);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_sample", sample, 1'b0);
    chk("async_rst_done", done, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(2);
    step(1'b1, 16'd1, 1'b0); idle(10);

`ifdef STROBE_ABORT_EN
    // Abort mid-ACTIVE of a three-pulse train
    step(1'b1, 16'd3, 1'b0); idle(3);
    step(1'b0, 16'd0, 1'b1); idle(10);
    // Abort in the last ACTIVE cycle keeps that cycle's sample
    step(1'b1, 16'd2, 1'b0); idle(4);
    step(1'b0, 16'd0, 1'b1); idle(10);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic st, ab;
      st = ($urandom_range(0, 3) == 0);
      ab = 1'b0;
`ifdef STROBE_ABORT_EN
      ab = ($urandom_range(0, 15) == 0);
`endif
      step(st, 16'($urandom_range(0, 3)), ab);
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
